// File: rtl/icache_if.sv
// Fetch-side and memory-side handshake bundle for the direct-mapped instruction cache.
// slave = cache view, master = fetch unit / memory controller view.
interface icache_if #(
  parameter int ADDR_W = 32
) ();
  logic              if_valid;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_ready;
  logic [31:0]       if_inst;
  logic              mem_rn;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ready;
  logic [31:0]       mem_value;

  modport slave (
    input  if_valid, if_addr, if_flush, mem_ready, mem_value,
    output if_ready, if_inst, mem_rn, mem_addr
  );

  modport master (
    output if_valid, if_addr, if_flush, mem_ready, mem_value,
    input  if_ready, if_inst, mem_rn, mem_addr
  );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped, single-word-line, read-only instruction cache with one request in flight.
// Optional hit/miss statistics counters are built when ICACHE_STATS_EN is defined.
module icache_direct #(
  parameter int INDEX_BITS = 6,
  parameter int ADDR_W     = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  icache_if.slave     bus,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);
  // state | meaning
  // IDLE  | accepting fetches; hits answered from the arrays
  // MISS  | read outstanding to the memory controller, waiting on mem_ready
  // RESP  | filled word presented with if_ready for one cycle

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

  typedef enum logic [1:0] {IDLE, MISS, RESP} state_t;

  state_t                  state;
  logic [ADDR_W-3:0]       req_word;
  logic [LINES-1:0]        valid_q;
  logic [TAG_W-1:0]        tag_arr  [LINES];
  logic [31:0]             data_arr [LINES];
  logic                    if_ready_q;
  logic [31:0]             if_inst_q;
  logic                    mem_rn_q;
  logic [ADDR_W-1:0]       mem_addr_q;
  logic                    cancel_q;

  logic [INDEX_BITS-1:0]   fetch_idx;
  logic [TAG_W-1:0]        fetch_tag;
  logic [INDEX_BITS-1:0]   req_idx;
  logic [TAG_W-1:0]        req_tag;
  logic                    hit;
  logic                    accept;
  logic                    fill;
  logic                    unused_offset;

  assign fetch_idx = bus.if_addr[INDEX_BITS+1:2];
  assign fetch_tag = bus.if_addr[ADDR_W-1:INDEX_BITS+2];
  assign req_idx   = req_word[INDEX_BITS-1:0];
  assign req_tag   = req_word[ADDR_W-3:INDEX_BITS];

  // Byte offset within the word is irrelevant to an instruction fetch.
  assign unused_offset = ^bus.if_addr[1:0];

  assign hit = valid_q[fetch_idx] && (tag_arr[fetch_idx] == fetch_tag);

  // The request served by a high if_ready is still presented that cycle, so skip it.
  assign accept = (state == IDLE) && bus.if_valid && !bus.if_flush && !if_ready_q;
  assign fill   = (state == MISS) && bus.mem_ready;

  always_ff @(posedge clk) begin
    if (!rst && rdy && fill) begin
      tag_arr[req_idx]  <= req_tag;
      data_arr[req_idx] <= bus.mem_value;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_word   <= '0;
      valid_q    <= '0;
      if_ready_q <= 1'b0;
      if_inst_q  <= '0;
      mem_rn_q   <= 1'b0;
      mem_addr_q <= '0;
      cancel_q   <= 1'b0;
    end else if (rdy) begin
      case (state)
        IDLE: begin
          if_ready_q <= 1'b0;
          if (accept) begin
            req_word <= bus.if_addr[ADDR_W-1:2];
            if (hit) begin
              if_ready_q <= 1'b1;
              if_inst_q  <= data_arr[fetch_idx];
            end else begin
              state      <= MISS;
              mem_rn_q   <= 1'b1;
              mem_addr_q <= {bus.if_addr[ADDR_W-1:2], 2'b00};
            end
          end
        end
        MISS: begin
          if (bus.mem_ready) begin
            // The fill is kept even when cancelled; only the response is dropped.
            valid_q[req_idx] <= 1'b1;
            mem_rn_q         <= 1'b0;
            if_inst_q        <= bus.mem_value;
            cancel_q         <= 1'b0;
            if (cancel_q || bus.if_flush) begin
              state <= IDLE;
            end else begin
              state      <= RESP;
              if_ready_q <= 1'b1;
            end
          end else if (bus.if_flush) begin
            cancel_q <= 1'b1;
          end
        end
        RESP: begin
          if_ready_q <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A redirect arriving while the fill response is on the bus withholds it.
  assign bus.if_ready = if_ready_q && !((state == RESP) && bus.if_flush);
  assign bus.if_inst  = if_inst_q;
  assign bus.mem_rn   = mem_rn_q;
  assign bus.mem_addr = mem_addr_q;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (rdy && accept) begin
      if (hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
      else     miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  assign hit_cnt  = 32'd0;
  assign miss_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct: a line-contents model plus protocol timing drives the
// expected outputs, and one negedge process compares them every cycle.
module tb_icache_direct;
`ifdef ICACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  icache_if #(.ADDR_W(32)) bus ();

  icache_direct #(.INDEX_BITS(6), .ADDR_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .bus      (bus.slave),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: which word address each line holds, and its data.
  logic [29:0] cache_word [int];
  logic [31:0] cache_data [int];
  int          exp_hit = 0;
  int          exp_miss = 0;
  logic        exp_ready = 1'b0;
  logic        exp_rn = 1'b0;
  logic [31:0] exp_inst = '0;
  logic [31:0] exp_maddr = '0;
  bit          check_en = 1'b0;

  logic [31:0] got_inst;
  logic [31:0] got_maddr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("if_ready", {31'd0, bus.if_ready}, {31'd0, exp_ready});
      chk("mem_rn", {31'd0, bus.mem_rn}, {31'd0, exp_rn});
      if (exp_ready) chk("if_inst", bus.if_inst, exp_inst);
      if (exp_rn) chk("mem_addr", bus.mem_addr, exp_maddr);
      chk("hit_cnt", hit_cnt, STATS ? exp_hit : 0);
      chk("miss_cnt", miss_cnt, STATS ? exp_miss : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    cache_word.delete();
    cache_data.delete();
    exp_hit = 0;
    exp_miss = 0;
    exp_ready = 1'b0;
    exp_rn = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.if_valid = 1'b0;
    bus.if_flush = 1'b0;
    bus.mem_ready = 1'b0;
    tick();
    model_clear();
    rst = 1'b0;
    tick();
  endtask

  // One fetch; on a miss memory answers in the lat-th cycle of mem_rn.
  // flush_at>0 raises if_flush during that cycle of the miss (lat = concurrent with mem_ready).
  task automatic fetch(input logic [31:0] addr, input int lat, input logic [31:0] data,
                       input int flush_at, output logic [31:0] g_inst, output logic [31:0] g_maddr);
    logic [29:0] w;
    int          idx;
    bit          h;
    bit          flushed;
    w = addr[31:2];
    idx = int'(w[5:0]);
    h = cache_word.exists(idx) && (cache_word[idx] == w);
    flushed = 1'b0;
    g_inst = 'x;
    g_maddr = 'x;
    bus.if_valid = 1'b1;
    bus.if_addr = addr;
    tick();
    if (h) begin
      exp_hit++;
      exp_ready = 1'b1;
      exp_inst = cache_data[idx];
      #3 g_inst = bus.if_inst;
      tick();
      exp_ready = 1'b0;
      bus.if_valid = 1'b0;
    end else begin
      exp_miss++;
      exp_rn = 1'b1;
      exp_maddr = {addr[31:2], 2'b00};
      #3 g_maddr = bus.mem_addr;
      for (int c = 1; c <= lat; c++) begin
        bus.if_flush = (c == flush_at);
        if (c == flush_at) begin
          flushed = 1'b1;
          bus.if_valid = 1'b0;
        end
        bus.mem_ready = (c == lat);
        bus.mem_value = data;
        tick();
      end
      bus.mem_ready = 1'b0;
      bus.if_flush = 1'b0;
      exp_rn = 1'b0;
      cache_word[idx] = w;
      cache_data[idx] = data;
      if (!flushed) begin
        exp_ready = 1'b1;
        exp_inst = data;
        #3 g_inst = bus.if_inst;
        tick();
        exp_ready = 1'b0;
      end
      bus.if_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    bus.if_valid = 1'b0;
    bus.if_addr = '0;
    bus.if_flush = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_value = '0;
    repeat (2) @(posedge clk);
    #1;
    check_en = 1'b1;
    #3 chk("rst_if_inst", bus.if_inst, 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // Cold miss then hit on the same word
    fetch(32'h0000_0000, 5, 32'h0000_0513, 0, got_inst, got_maddr);
    chk("cold_maddr", got_maddr, 32'h0000_0000);
    chk("cold_inst", got_inst, 32'h0000_0513);
    fetch(32'h0000_0000, 5, 32'hBAD0_0000, 0, got_inst, got_maddr);
    chk("rehit_inst", got_inst, 32'h0000_0513);

    // Byte offset ignored
    fetch(32'h0000_0007, 2, 32'h0040_0093, 0, got_inst, got_maddr);
    chk("off_maddr", got_maddr, 32'h0000_0004);
    fetch(32'h0000_0004, 2, 32'hBAD0_0001, 0, got_inst, got_maddr);
    chk("off_hit_inst", got_inst, 32'h0040_0093);

    // Same-index conflict from a clean state
    do_reset();
    fetch(32'h0000_0004, 3, 32'h0040_0093, 0, got_inst, got_maddr);
    fetch(32'h0000_0104, 1, 32'h0000_0113, 0, got_inst, got_maddr);
    chk("conf_inst", got_inst, 32'h0000_0113);
    fetch(32'h0000_0004, 4, 32'h0040_0093, 0, got_inst, got_maddr);
    chk("conf_maddr", got_maddr, 32'h0000_0004);
    #3;
    chk("conf_miss_cnt", miss_cnt, STATS ? 32'd3 : 32'd0);
    chk("conf_hit_cnt", hit_cnt, 32'd0);
    tick();

    // Flush during a miss: fill kept, response dropped
    fetch(32'h0000_0200, 4, 32'hDEAD_BEEF, 1, got_inst, got_maddr);
    tick();
    fetch(32'h0000_0200, 4, 32'hBAD0_0002, 0, got_inst, got_maddr);
    chk("flush_hit_inst", got_inst, 32'hDEAD_BEEF);

    // Flush coincident with mem_ready
    fetch(32'h0000_0300, 2, 32'h0000_0297, 2, got_inst, got_maddr);
    fetch(32'h0000_0300, 2, 32'hBAD0_0003, 0, got_inst, got_maddr);
    chk("cflush_hit_inst", got_inst, 32'h0000_0297);

    // Flush while idle: never accepted
    bus.if_valid = 1'b1;
    bus.if_addr = 32'h0000_0800;
    bus.if_flush = 1'b1;
    tick();
    bus.if_valid = 1'b0;
    bus.if_flush = 1'b0;
    tick();

    // rdy low holds a hit pulse
    bus.if_valid = 1'b1;
    bus.if_addr = 32'h0000_0300;
    tick();
    exp_hit++;
    exp_ready = 1'b1;
    exp_inst = 32'h0000_0297;
    rdy = 1'b0;
    repeat (2) tick();
    rdy = 1'b1;
    tick();
    exp_ready = 1'b0;
    bus.if_valid = 1'b0;
    tick();

    // rdy low mid-miss with mem_ready held
    bus.if_valid = 1'b1;
    bus.if_addr = 32'h0000_0500;
    tick();
    exp_miss++;
    exp_rn = 1'b1;
    exp_maddr = 32'h0000_0500;
    tick();
    bus.mem_ready = 1'b1;
    bus.mem_value = 32'h0010_0073;
    rdy = 1'b0;
    repeat (4) tick();
    rdy = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    exp_rn = 1'b0;
    cache_word[0] = 30'h140;
    cache_data[0] = 32'h0010_0073;
    exp_ready = 1'b1;
    exp_inst = 32'h0010_0073;
    #3 chk("frz_inst", bus.if_inst, 32'h0010_0073);
    tick();
    exp_ready = 1'b0;
    bus.if_valid = 1'b0;
    fetch(32'h0000_0500, 2, 32'hBAD0_0004, 0, got_inst, got_maddr);
    chk("frz_hit_inst", got_inst, 32'h0010_0073);

    // Reset mid-miss abandons the request and invalidates everything
    bus.if_valid = 1'b1;
    bus.if_addr = 32'h0000_0600;
    tick();
    exp_miss++;
    exp_rn = 1'b1;
    exp_maddr = 32'h0000_0600;
    tick();
    rst = 1'b1;
    bus.if_valid = 1'b0;
    tick();
    model_clear();
    rst = 1'b0;
    tick();
    fetch(32'h0000_0200, 2, 32'hDEAD_BEEF, 0, got_inst, got_maddr);
    chk("post_rst_maddr", got_maddr, 32'h0000_0200);
    chk("post_rst_inst", got_inst, 32'hDEAD_BEEF);

    tick();
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
